uart_rx_oversample: RTL and testbench
=====================================

Name: uart_rx_oversample

Overview:
- UART receiver: the receive-side consumer of the baud generator's oversampled rx timing.
- Recovers asynchronous serial frames from pin `rxd`: 1 start bit, DATA_BITS data bits LSB first, optional parity, 1 stop bit.
- Runs entirely on the 100 MHz system clock, gated by a single-cycle `rx_tick` enable at OVERSAMPLE × baud (the rising edge of the baud generator's rx output, edge-detected upstream).
- Presents each received byte with a one-cycle valid strobe and error flags to the downstream command/FIFO logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 8, `rx_tick` pulses per bit period; must be even, ≥4.
- PARITY_EN, 0, 1 = parity bit present between data and stop.
- PARITY_ODD, 0, 1 = odd parity expected, 0 = even (ignored when PARITY_EN = 0).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_tick  in  1  one-clk-wide enable pulse at OVERSAMPLE × baud; all bit timing is counted in these ticks.
- rxd  in  1  asynchronous serial input; idle high.
- data  out  DATA_BITS  last received data word.
- data_valid  out  1  one-clk pulse: `data` and error flags updated.
- parity_err  out  1  parity mismatch for the current `data`; held until the next `data_valid`.
- frame_err  out  1  stop bit sampled low for the current `data`; held until the next `data_valid`.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, tick counter = 0, bit counter = 0, shift register = 0.
  - data = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - Synchronizer flops preset to 1.
- Input synchronizer: `rxd` passes through a 2-FF synchronizer clocked by clk, output `rxd_s`. All FSM decisions use `rxd_s`; they are never made on raw `rxd`.
- The FSM advances only on clk edges where rx_tick = 1, except: the `data_valid` clear and async reset are evaluated every clk.
- States:
  - IDLE: on a tick with rxd_s = 0 → START, tick_cnt = 0.
  - START: tick_cnt++ each tick. On the tick where tick_cnt = OVERSAMPLE/2 − 1 (mid start bit), sample rxd_s:
    - 0 → DATA, tick_cnt = 0, bit_cnt = 0.
    - 1 → IDLE (false start; no flags, no `data_valid`).
  - DATA: tick_cnt++ each tick. On the tick where tick_cnt = OVERSAMPLE − 1:
    - shift rxd_s into the MSB of the shift register (right shift, so the LSB arrives first); tick_cnt = 0; bit_cnt++.
    - After bit DATA_BITS − 1 → PARITY if PARITY_EN, else STOP.
  - PARITY: same timing as DATA. Sampled bit is compared against the XOR of the data bits, inverted when PARITY_ODD = 1. The mismatch result is latched internally → STOP.
  - STOP: same timing as DATA. At the sample tick:
    - data ← shift register; data_valid = 1 for exactly one clk.
    - parity_err ← latched mismatch (0 if PARITY_EN = 0).
    - frame_err ← ~rxd_s.
    - rxd_s = 1 → IDLE; rxd_s = 0 → BREAK.
  - BREAK: wait for a tick with rxd_s = 1 → IDLE. No further `data_valid` while in BREAK, so a held-low line produces exactly one frame_err word.
- Latency: `data_valid` rises on the clk edge of the mid-stop-bit sample tick; `data` is stable from that edge onward.
- Back-to-back frames: a start bit immediately following the stop bit is caught because STOP returns to IDLE at mid-stop, leaving half a bit of margin.
- Ticks are counted, not clk cycles. rx_tick held 0 freezes the FSM indefinitely, with no timeout.
- Reset asserted mid-frame aborts the frame immediately. No `data_valid` is produced for the partial frame, and `data` returns to 0.
- A glitch on `rxd` shorter than OVERSAMPLE/2 ticks in IDLE is rejected by the mid-start check.

Test Plan:
1. 8N1, OVERSAMPLE = 8, rx_tick every 10 clks, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) → single `data_valid` pulse, data = 0xA5, parity_err = 0, frame_err = 0, busy low afterwards.
2. Drive rxd low for 2 ticks, then high → FSM returns to IDLE, no `data_valid`, flags unchanged.
3. Send 0x3C with stop bit forced low, line held low for 30 ticks, then high → one `data_valid` with data = 0x3C, frame_err = 1; no second strobe; then a following 0x55 frame → data = 0x55, frame_err = 0.
4. PARITY_EN = 1, PARITY_ODD = 0, send 0x07 with parity bit 0 (wrong; correct is 1) → parity_err = 1. Repeat with parity bit 1 → parity_err = 0.
5. Pull rst low during data bit 4 of 0xFF, release, then send 0x81 → no strobe for the aborted frame, outputs zero during reset, next strobe gives data = 0x81.
6. Three frames 0x01, 0x80, 0xFF back-to-back, each with exactly one stop bit → three `data_valid` pulses in order with the matching data and no errors.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// UART receiver: 2-FF synchronised rxd, 1 start / DATA_BITS data (LSB first) /
// optional parity / 1 stop, all timing counted in rx_tick (OVERSAMPLE x baud).
// Ports: clk, rst (async active-low), rx_tick, rxd in;
//        data, data_valid (1-clk strobe), parity_err, frame_err, busy out.
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);
    localparam logic          PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_mis_q, par_mis_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;

    logic rxd_s;
    logic at_sample;

    assign rxd_s     = sync_q[1];
    assign at_sample = (tick_cnt_q == LAST_TICK);

    always_comb begin
        sync_d       = {sync_q[0], rxd};
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_mis_d    = par_mis_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (rx_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    // Mid-start recheck rejects short glitches.
                    if (tick_cnt_q == MID_TICK) begin
                        if (!rxd_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (at_sample) begin
                        shift_d    = {rxd_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = PAR_ON ? PARITY : STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (at_sample) begin
                        par_mis_d  = rxd_s ^ (^shift_q) ^ ODD;
                        tick_cnt_d = '0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (at_sample) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        parity_err_d = PAR_ON & par_mis_q;
                        frame_err_d  = ~rxd_s;
                        tick_cnt_d   = '0;
                        // Leaving at mid-stop leaves margin for a back-to-back start.
                        state_d      = rxd_s ? IDLE : BRK;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                BRK: begin
                    if (rxd_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_mis_q    <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_mis_q    <= par_mis_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: an 8N1 instance and an 8E1 instance
// share clk, rst and rx_tick (one pulse every 10 clks, OVERSAMPLE = 8).
module tb_uart_rx_oversample;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_tick = 1'b0;
    logic       rxd_a = 1'b1;
    logic       rxd_p = 1'b1;

    logic [7:0] data_a, data_p;
    logic       dv_a, pe_a, fe_a, busy_a;
    logic       dv_p, pe_p, fe_p, busy_p;

    int n_checks = 0;
    int n_errs   = 0;
    int tick_div = 0;
    bit sel      = 1'b0;

    int         acnt = 0;
    int         pcnt = 0;
    logic [7:0] a_d  [64];
    logic       a_fe [64];
    logic       a_pe [64];

    uart_rx_oversample dut_a (
        .clk        (clk),
        .rst        (rst),
        .rx_tick    (rx_tick),
        .rxd        (rxd_a),
        .data       (data_a),
        .data_valid (dv_a),
        .parity_err (pe_a),
        .frame_err  (fe_a),
        .busy       (busy_a)
    );

    uart_rx_oversample #(
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut_p (
        .clk        (clk),
        .rst        (rst),
        .rx_tick    (rx_tick),
        .rxd        (rxd_p),
        .data       (data_p),
        .data_valid (dv_p),
        .parity_err (pe_p),
        .frame_err  (fe_p),
        .busy       (busy_p)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div = (tick_div == 9) ? 0 : tick_div + 1;
        rx_tick  = (tick_div == 0);
    end

    always @(negedge clk) begin
        if (dv_a) begin
            if (acnt < 64) begin
                a_d[acnt]  = data_a;
                a_fe[acnt] = fe_a;
                a_pe[acnt] = pe_a;
            end
            acnt++;
        end
        if (dv_p) pcnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!rx_tick);
            #1;
        end
    endtask

    task automatic line(input bit v);
        if (sel) rxd_p = v;
        else     rxd_a = v;
    endtask

    task automatic send(input logic [7:0] d, input bit pen,
                        input bit pb, input bit sb);
        line(1'b0);
        ticks(8);
        for (int i = 0; i < 8; i++) begin
            line(d[i]);
            ticks(8);
        end
        if (pen) begin
            line(pb);
            ticks(8);
        end
        line(sb);
        ticks(8);
    endtask

    initial begin
        int c0;

        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_a, 8'h00);
        check("rst_dv", dv_a, 1'b0);
        check("rst_pe", pe_a, 1'b0);
        check("rst_fe", fe_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        rst = 1'b1;
        ticks(2);

        // 0xA5 8N1
        c0 = acnt;
        send(8'hA5, 1'b0, 1'b0, 1'b1);
        check("a5_cnt", acnt, c0 + 1);
        check("a5_data", data_a, 8'hA5);
        check("a5_pe", pe_a, 1'b0);
        check("a5_fe", fe_a, 1'b0);
        check("a5_busy", busy_a, 1'b0);

        // 2-tick glitch
        c0 = acnt;
        line(1'b0);
        ticks(2);
        check("gl_busy_hi", busy_a, 1'b1);
        line(1'b1);
        ticks(10);
        check("gl_cnt", acnt, c0);
        check("gl_busy", busy_a, 1'b0);
        check("gl_data", data_a, 8'hA5);
        check("gl_fe", fe_a, 1'b0);

        // framing error + break, then recovery
        c0 = acnt;
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        ticks(30);
        check("brk_cnt", acnt, c0 + 1);
        check("brk_data", data_a, 8'h3C);
        check("brk_fe", fe_a, 1'b1);
        check("brk_busy", busy_a, 1'b1);
        line(1'b1);
        ticks(8);
        check("brk_cnt2", acnt, c0 + 1);
        check("brk_idle", busy_a, 1'b0);
        send(8'h55, 1'b0, 1'b0, 1'b1);
        check("r55_cnt", acnt, c0 + 2);
        check("r55_data", data_a, 8'h55);
        check("r55_fe", fe_a, 1'b0);

        // even parity on 0x07: correct bit is 1
        sel = 1'b1;
        c0  = pcnt;
        send(8'h07, 1'b1, 1'b0, 1'b1);
        check("par_bad_cnt", pcnt, c0 + 1);
        check("par_bad_data", data_p, 8'h07);
        check("par_bad_pe", pe_p, 1'b1);
        check("par_bad_fe", fe_p, 1'b0);
        send(8'h07, 1'b1, 1'b1, 1'b1);
        check("par_ok_cnt", pcnt, c0 + 2);
        check("par_ok_pe", pe_p, 1'b0);
        sel = 1'b0;

        // reset during data bit 4 of 0xFF
        c0 = acnt;
        line(1'b0);
        ticks(8);
        for (int i = 0; i < 4; i++) begin
            line(1'b1);
            ticks(8);
        end
        line(1'b1);
        ticks(3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_data", data_a, 8'h00);
        check("mrst_busy", busy_a, 1'b0);
        check("mrst_dv", dv_a, 1'b0);
        check("mrst_pdata", data_p, 8'h00);
        ticks(2);
        check("mrst_hold", data_a, 8'h00);
        rst = 1'b1;
        ticks(16);
        check("mrst_cnt", acnt, c0);
        check("mrst_idle", busy_a, 1'b0);
        send(8'h81, 1'b0, 1'b0, 1'b1);
        check("r81_cnt", acnt, c0 + 1);
        check("r81_data", data_a, 8'h81);

        // back-to-back frames
        c0 = acnt;
        send(8'h01, 1'b0, 1'b0, 1'b1);
        send(8'h80, 1'b0, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b0, 1'b1);
        check("b2b_cnt", acnt, c0 + 3);
        check("b2b_d0", a_d[c0], 8'h01);
        check("b2b_d1", a_d[c0+1], 8'h80);
        check("b2b_d2", a_d[c0+2], 8'hFF);
        check("b2b_err",
              {a_fe[c0], a_fe[c0+1], a_fe[c0+2],
               a_pe[c0], a_pe[c0+1], a_pe[c0+2]}, 6'b0);
        check("b2b_busy", busy_a, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
